// File: rtl/fib_result_checker_if.sv
// ---------------------------------------------------------------------------
// fib_result_checker_if
//
// Purpose : bundles the signals between the RISC-V core probe points and the
//           Fibonacci self-check stage.
//
// Signals :
//   pc_in, instruction_in, register_10_in : core observation points (32 bit)
//   done, pass, fail, hang                : sticky status flags
//   match_count                           : correct distinct x10 values seen
//   expected_value                        : next value expected in x10
//   fail_value                            : x10 value or PC captured on failure
//   dbg_state                             : checker FSM state, for observation
//
// There is no handshake: the probe signals are plain level samples taken on
// every rising clock edge, and the status outputs are plain registered levels.
//
// Modports:
//   master : the side that drives the probe signals (core wrapper or bench)
//   slave  : the checker
// ---------------------------------------------------------------------------
interface fib_result_checker_if;
    logic [31:0] pc_in;
    logic [31:0] instruction_in;
    logic [31:0] register_10_in;
    logic        done;
    logic        pass;
    logic        fail;
    logic        hang;
    logic [5:0]  match_count;
    logic [31:0] expected_value;
    logic [31:0] fail_value;
    logic [1:0]  dbg_state;

    modport master (
        output pc_in, instruction_in, register_10_in,
        input  done, pass, fail, hang, match_count, expected_value,
               fail_value, dbg_state
    );

    modport slave (
        input  pc_in, instruction_in, register_10_in,
        output done, pass, fail, hang, match_count, expected_value,
               fail_value, dbg_state
    );
endinterface

// File: rtl/fib_result_checker.sv
// ---------------------------------------------------------------------------
// fib_result_checker
//
// Purpose : samples the core's PC, instruction and x10 every clock and checks
//           that the successive distinct x10 values follow the Fibonacci
//           sequence 1, 2, 3, 5, 8, ... up to F(TARGET_N). Results are
//           reported on sticky, registered status outputs.
//
// Parameters:
//   TARGET_N    : final Fibonacci index (3..47); F(10) = 55
//   WDOG_CYCLES : consecutive cycles of unchanged PC treated as a hang
//
// Ports:
//   clock : sole clock, rising edge
//   reset : synchronous, active-high, clears all state
//   bus   : fib_result_checker_if.slave (probe inputs, status outputs,
//           dbg_state exposing the FSM state)
//
// Build option:
//   FIB_CHECK_WATCHDOG_EN : when defined, a PC-stall watchdog is compiled in
//                           and drives hang; otherwise hang is tied to 0.
// ---------------------------------------------------------------------------
module fib_result_checker #(
    parameter int TARGET_N    = 10,
    parameter int WDOG_CYCLES = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    fib_result_checker_if.slave  bus
);

    localparam logic [1:0] ST_PRIME = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PASS  = 2'd2;
    localparam logic [1:0] ST_FAIL  = 2'd3;

    localparam logic [31:0] ECALL_INSN = 32'h0000_0073;

    // Elaboration-time Fibonacci: F(0)=0, F(1)=1. Only f0 is returned, so the
    // wrap of the look-ahead term f1 near the top of the range is harmless.
    function automatic logic [31:0] fib_const(input int n);
        logic [31:0] f0;
        logic [31:0] f1;
        logic [31:0] t;
        f0 = 32'd0;
        f1 = 32'd1;
        for (int i = 0; i < n; i++) begin
            t  = f0 + f1;
            f0 = f1;
            f1 = t;
        end
        return f0;
    endfunction

    localparam logic [31:0] FIB_TARGET = fib_const(TARGET_N);

    if (TARGET_N < 3 || TARGET_N > 47 || WDOG_CYCLES < 1 || WDOG_CYCLES > 65535) begin : g_bad_cfg
        $error("fib_result_checker: TARGET_N or WDOG_CYCLES out of range");
    end

    logic [1:0]  r_state;
    logic [31:0] r_prev;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [5:0]  r_match_count;
    logic        r_done;
    logic        r_pass;
    logic        r_fail;
    logic [31:0] r_fail_value;

    logic w_change;
    logic w_hit;
    logic w_target;
    logic w_mismatch;
    logic w_ecall;

    // Only transitions of x10 are judged; a repeated value (including the
    // second 1 of the sequence) is never compared against the generator.
    assign w_change   = (bus.register_10_in != r_prev);
    assign w_hit      = w_change && (bus.register_10_in == r_a);
    assign w_target   = w_hit && (bus.register_10_in == FIB_TARGET);
    assign w_mismatch = w_change && !w_hit;
    assign w_ecall    = (bus.instruction_in == ECALL_INSN);

`ifdef FIB_CHECK_WATCHDOG_EN
    localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYCLES - 1);

    logic [31:0] r_prev_pc;
    logic [15:0] r_wdog_cnt;
    logic        r_hang;
    logic        w_pc_same;
    logic        w_wdog_trip;

    assign w_pc_same   = (bus.pc_in == r_prev_pc);
    // The sample that would bring the count to WDOG_CYCLES is the trip point.
    assign w_wdog_trip = w_pc_same && (r_wdog_cnt == WDOG_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_prev_pc  <= 32'd0;
            r_wdog_cnt <= 16'd0;
        end else if (r_state == ST_PRIME) begin
            r_prev_pc  <= bus.pc_in;
            r_wdog_cnt <= 16'd0;
        end else if (r_state == ST_RUN) begin
            r_prev_pc  <= bus.pc_in;
            r_wdog_cnt <= w_pc_same ? (r_wdog_cnt + 16'd1) : 16'd0;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_PRIME;
            r_prev        <= 32'd0;
            r_a           <= 32'd1;
            r_b           <= 32'd2;
            r_match_count <= 6'd0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_fail        <= 1'b0;
            r_fail_value  <= 32'd0;
`ifdef FIB_CHECK_WATCHDOG_EN
            r_hang        <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_PRIME: begin
                    r_prev  <= bus.register_10_in;
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    r_prev <= bus.register_10_in;
                    if (w_hit) begin
                        if (r_match_count != 6'd63) begin
                            r_match_count <= r_match_count + 6'd1;
                        end
                        r_a <= r_b;
                        r_b <= r_a + r_b;
                    end
                    // Priority: target match, mismatch, ecall, watchdog.
                    if (w_target) begin
                        r_state <= ST_PASS;
                        r_done  <= 1'b1;
                        r_pass  <= 1'b1;
                    end else if (w_mismatch) begin
                        r_state      <= ST_FAIL;
                        r_done       <= 1'b1;
                        r_fail       <= 1'b1;
                        r_fail_value <= bus.register_10_in;
                    end else if (w_ecall) begin
                        r_state      <= ST_FAIL;
                        r_done       <= 1'b1;
                        r_fail       <= 1'b1;
                        r_fail_value <= bus.pc_in;
`ifdef FIB_CHECK_WATCHDOG_EN
                    end else if (w_wdog_trip) begin
                        r_state      <= ST_FAIL;
                        r_done       <= 1'b1;
                        r_fail       <= 1'b1;
                        r_hang       <= 1'b1;
                        r_fail_value <= bus.pc_in;
`endif
                    end
                end
                default: begin
                    // PASS and FAIL are terminal; only reset leaves them.
                    r_state <= r_state;
                end
            endcase
        end
    end

    assign bus.done           = r_done;
    assign bus.pass           = r_pass;
    assign bus.fail           = r_fail;
`ifdef FIB_CHECK_WATCHDOG_EN
    assign bus.hang           = r_hang;
`else
    assign bus.hang           = 1'b0;
`endif
    assign bus.match_count    = r_match_count;
    assign bus.expected_value = r_a;
    assign bus.fail_value     = r_fail_value;
    assign bus.dbg_state      = r_state;

endmodule
